// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data bus load/store issue, load alignment, MEM/WB register
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubbleHold,
  input  logic                  in_valid,
  input  logic [XLEN-1:0]       in_aluOut,
  input  logic [XLEN-1:0]       in_rs2,
  input  logic                  in_memRead,
  input  logic                  in_memWrite,
  input  logic [1:0]            in_memSize,
  input  logic                  in_memUnsigned,
  input  logic                  in_isWriteBack,
  input  logic [REG_ADDR_W-1:0] in_wd,
  input  logic [XLEN-1:0]       in_instrAddr,
  input  logic [31:0]           in_instr,
  output logic                  dreq_valid,
  output logic [XLEN-1:0]       dreq_addr,
  output logic                  dreq_write,
  output logic [7:0]            dreq_strobe,
  output logic [XLEN-1:0]       dreq_data,
  input  logic                  dresp_ok,
  input  logic [XLEN-1:0]       dresp_data,
  output logic                  stall,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_result,
  output logic                  out_isWriteBack,
  output logic [REG_ADDR_W-1:0] out_wd,
  output logic [XLEN-1:0]       out_instrAddr,
  output logic [31:0]           out_instr
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  out_exception
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nxt;

  // Operation captured at issue time; upstream is frozen but WAIT never looks at it.
  logic [2:0]            c_off;
  logic [1:0]            c_size;
  logic                  c_uns;
  logic                  c_load;
  logic                  c_wb;
  logic [REG_ADDR_W-1:0] c_wd;
  logic [XLEN-1:0]       c_alu;
  logic [XLEN-1:0]       c_pc;
  logic [31:0]           c_instr;

  logic            mem_op;
  logic            trap;
  logic            issue;
  logic            stall_c;
  logic [7:0]      byte_mask;
  logic [7:0]      strobe_c;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_val;

  assign mem_op = in_memRead | in_memWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  logic [3:0] size_mask;
  assign size_mask = (4'd1 << in_memSize) - 4'd1;
  assign trap      = mem_op & (|(in_aluOut[2:0] & size_mask[2:0]));
`else
  assign trap = 1'b0;
`endif

  assign issue = in_valid & mem_op & ~trap;

  always_comb begin
    byte_mask = 8'hFF;
    case (in_memSize)
      2'd0:    byte_mask = 8'h01;
      2'd1:    byte_mask = 8'h03;
      2'd2:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  end

  // 8-bit shift drops lanes past byte 7 for misaligned accesses.
  assign strobe_c = byte_mask << in_aluOut[2:0];

  assign shifted = dresp_data >> {c_off, 3'b000};

  always_comb begin
    load_val = shifted;
    case (c_size)
      2'd0:    load_val = {{(XLEN-8){~c_uns & shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = {{(XLEN-16){~c_uns & shifted[15]}}, shifted[15:0]};
      2'd2:    load_val = {{(XLEN-32){~c_uns & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = WAIT;
          stall_c   = 1'b1;
        end
      end
      WAIT: begin
        if (dresp_ok) state_nxt = IDLE;
        else          stall_c   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = stall_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      dreq_valid      <= 1'b0;
      dreq_addr       <= '0;
      dreq_write      <= 1'b0;
      dreq_strobe     <= 8'h00;
      dreq_data       <= '0;
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_isWriteBack <= 1'b0;
      out_wd          <= '0;
      out_instrAddr   <= '0;
      out_instr       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      out_exception   <= 1'b0;
`endif
      c_off           <= 3'd0;
      c_size          <= 2'd0;
      c_uns           <= 1'b0;
      c_load          <= 1'b0;
      c_wb            <= 1'b0;
      c_wd            <= '0;
      c_alu           <= '0;
      c_pc            <= '0;
      c_instr         <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          out_exception <= 1'b0;
`endif
          if (in_valid && (!mem_op || trap)) begin
            out_valid       <= ~bubbleHold;
            out_result      <= in_aluOut;
            out_isWriteBack <= in_isWriteBack & ~trap;
            out_wd          <= in_wd;
            out_instrAddr   <= in_instrAddr;
            out_instr       <= in_instr;
`ifdef MEM_MISALIGN_TRAP_EN
            out_exception   <= trap;
`endif
          end
          if (issue) begin
            dreq_valid  <= 1'b1;
            dreq_addr   <= {in_aluOut[XLEN-1:3], 3'b000};
            dreq_write  <= in_memWrite;
            dreq_strobe <= strobe_c;
            dreq_data   <= in_rs2 << {in_aluOut[2:0], 3'b000};
            c_off       <= in_aluOut[2:0];
            c_size      <= in_memSize;
            c_uns       <= in_memUnsigned;
            c_load      <= in_memRead & ~in_memWrite;
            c_wb        <= in_isWriteBack;
            c_wd        <= in_wd;
            c_alu       <= in_aluOut;
            c_pc        <= in_instrAddr;
            c_instr     <= in_instr;
          end
        end
        WAIT: begin
          if (dresp_ok) begin
            dreq_valid      <= 1'b0;
            out_valid       <= ~bubbleHold;
            out_result      <= c_load ? load_val : c_alu;
            out_isWriteBack <= c_wb;
            out_wd          <= c_wd;
            out_instrAddr   <= c_pc;
            out_instr       <= c_instr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with randomized traffic and a bus responder
// Build with MEM_MISALIGN_TRAP_EN defined to exercise the misaligned-access trap.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        bubbleHold;
  logic        in_valid;
  logic [63:0] in_aluOut;
  logic [63:0] in_rs2;
  logic        in_memRead;
  logic        in_memWrite;
  logic [1:0]  in_memSize;
  logic        in_memUnsigned;
  logic        in_isWriteBack;
  logic [4:0]  in_wd;
  logic [63:0] in_instrAddr;
  logic [31:0] in_instr;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic        dreq_write;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        stall;
  logic        out_valid;
  logic [63:0] out_result;
  logic        out_isWriteBack;
  logic [4:0]  out_wd;
  logic [63:0] out_instrAddr;
  logic [31:0] out_instr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        out_exception;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .bubbleHold(bubbleHold), .in_valid(in_valid),
    .in_aluOut(in_aluOut), .in_rs2(in_rs2), .in_memRead(in_memRead),
    .in_memWrite(in_memWrite), .in_memSize(in_memSize), .in_memUnsigned(in_memUnsigned),
    .in_isWriteBack(in_isWriteBack), .in_wd(in_wd), .in_instrAddr(in_instrAddr),
    .in_instr(in_instr), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_write(dreq_write), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data), .stall(stall), .out_valid(out_valid),
    .out_result(out_result), .out_isWriteBack(out_isWriteBack), .out_wd(out_wd),
    .out_instrAddr(out_instrAddr), .out_instr(out_instr)
`ifdef MEM_MISALIGN_TRAP_EN
    , .out_exception(out_exception)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    logic        wr;
    logic [7:0]  strb;
    logic [63:0] data;
    logic [63:0] rdata;
    int          delay;
  } bus_t;

  typedef struct {
    logic [63:0] result;
    logic        wb;
    logic [4:0]  wd;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc;
  } out_t;

  bus_t bus_q[$];
  out_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-lane view of the 8-byte bus word.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off, input int sz, input logic uns);
    int nbytes = 1 << sz;
    logic [63:0] v = '0;
    for (int i = 0; i < nbytes; i++)
      if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!uns && nbytes < 8 && v[8*nbytes-1])
      for (int b = 8*nbytes; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] ref_strobe(input int off, input int sz);
    logic [7:0] s = '0;
    for (int i = 0; i < (1 << sz); i++)
      if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_sdata(input logic [63:0] rs2, input int off);
    logic [63:0] d = '0;
    for (int i = 0; i + off < 8; i++) d[8*(i+off) +: 8] = rs2[8*i +: 8];
    return d;
  endfunction

  // Present one entry, record expectations, hold it until the stage stops stalling.
  task automatic issue(input logic v, input logic [63:0] alu, input logic [63:0] rs2,
                       input logic rd, input logic wr, input int sz, input logic uns,
                       input logic wb, input logic [4:0] wd, input logic bh,
                       input logic [63:0] rdata, input int dly, output int stall_cnt);
    bit   memop, mis, trap, done;
    int   off;
    bus_t b;
    out_t o;
    in_valid = v; in_aluOut = alu; in_rs2 = rs2; in_memRead = rd; in_memWrite = wr;
    in_memSize = 2'(sz); in_memUnsigned = uns; in_isWriteBack = wb; in_wd = wd;
    bubbleHold = bh; in_instrAddr = {$urandom, $urandom}; in_instr = $urandom;
    off   = int'(alu[2:0]);
    memop = rd | wr;
    mis   = (alu % (64'd1 << sz)) != 0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap  = memop && mis;
`else
    trap  = 1'b0;
`endif
    if (v && memop && !trap) begin
      b.addr = alu & ~64'h7; b.wr = wr; b.strb = ref_strobe(off, sz);
      b.data = ref_sdata(rs2, off); b.rdata = rdata; b.delay = dly;
      bus_q.push_back(b);
    end
    if (v && !bh) begin
      o.result = (memop && !trap && rd && !wr) ? ref_load(rdata, off, sz, uns) : alu;
      o.wb = wb && !trap; o.wd = wd; o.pc = in_instrAddr; o.instr = in_instr; o.exc = trap;
      sb_q.push_back(o);
    end
    stall_cnt = 0;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk); #2;
      if (!stall) done = 1;
      else stall_cnt++;
    end
    if (!done) chk("stall_timeout", 64'(stall), 64'h0);
    @(posedge clk); #1;
  endtask

  // Bus responder: checks each request against the model, holds it, then pulses dresp_ok.
  initial begin
    bus_t r;
    dresp_ok = 1'b0;
    dresp_data = '0;
    forever begin
      @(negedge clk);
      if (dreq_valid && !rst) begin
        if (bus_q.size() == 0) begin
          chk("req_unexpected", 64'(dreq_valid), 64'h0);
        end else begin
          r = bus_q.pop_front();
          chk("req_addr", dreq_addr, r.addr);
          chk("req_write", 64'(dreq_write), 64'(r.wr));
          chk("req_strobe", 64'(dreq_strobe), 64'(r.strb));
          if (r.wr) chk("req_data", dreq_data, r.data);
          for (int d = 0; d < r.delay; d++) begin
            @(negedge clk);
            if (dreq_valid)
              chk("req_hold", {dreq_addr[63:3], dreq_write, dreq_strobe[1:0]},
                  {r.addr[63:3], r.wr, r.strb[1:0]});
          end
          dresp_ok = 1'b1;
          dresp_data = r.rdata;
          @(negedge clk);
          dresp_ok = 1'b0;
          dresp_data = {$urandom, $urandom};
        end
      end
    end
  end

  // Monitor: every presented MEM/WB entry must match the oldest expectation.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb_q.size() == 0) begin
          chk("out_unexpected", 64'(out_valid), 64'h0);
        end else begin
          e = sb_q.pop_front();
          if (!e.exc) chk("out_result", out_result, e.result);
          chk("out_wb", 64'(out_isWriteBack), 64'(e.wb));
          chk("out_wd", 64'(out_wd), 64'(e.wd));
          chk("out_pc", out_instrAddr, e.pc);
          chk("out_instr", 64'(out_instr), 64'(e.instr));
`ifdef MEM_MISALIGN_TRAP_EN
          chk("out_exc", 64'(out_exception), 64'(e.exc));
`endif
        end
      end
    end
  end

  initial begin
    int   sc;
    int   op;
    time  t0;
    bus_t b;
    rst = 1'b1; bubbleHold = 0; in_valid = 0; in_aluOut = '0; in_rs2 = '0;
    in_memRead = 0; in_memWrite = 0; in_memSize = 0; in_memUnsigned = 0;
    in_isWriteBack = 0; in_wd = 0; in_instrAddr = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_dreq_valid", 64'(dreq_valid), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_strobe", 64'(dreq_strobe), 64'h0);
    chk("rst_result", out_result, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(1, 64'h1234, 64'h0, 0, 0, 0, 0, 1, 5'd5, 0, 64'h0, 0, sc);
    chk("alu_stall_cycles", 64'(sc), 64'd0);

    issue(1, 64'h1003, 64'h0, 1, 0, 0, 0, 1, 5'd7, 0, 64'h0000_0000_8000_0000, 3, sc);
    chk("lb_stall_cycles", 64'(sc), 64'd4);
    issue(1, 64'h1003, 64'h0, 1, 0, 0, 1, 1, 5'd8, 0, 64'h0000_0000_8000_0000, 1, sc);

    issue(1, 64'h2006, 64'hABCD, 0, 1, 1, 0, 0, 5'd0, 0, 64'h0, 2, sc);
    issue(1, 64'h3006, 64'h1122_3344, 0, 1, 2, 0, 0, 5'd0, 0, 64'h0, 0, sc);
    issue(1, 64'h3002, 64'h0, 1, 0, 2, 0, 1, 5'd9, 0, 64'h8877_6655_4433_2211, 0, sc);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("trap_stall_cycles", 64'(sc), 64'd0);
    chk("trap_no_req", 64'(dreq_valid), 64'h0);
`endif
    issue(1, 64'h4010, 64'h0, 1, 1, 3, 0, 1, 5'd3, 0, 64'h0, 0, sc);

    issue(1, 64'h5555, 64'h0, 0, 0, 0, 0, 1, 5'd4, 1, 64'h0, 0, sc);
    issue(0, 64'h6666, 64'h0, 1, 0, 0, 0, 1, 5'd4, 0, 64'h0, 0, sc);
    chk("invalid_stall", 64'(sc), 64'd0);

    t0 = $time;
    for (int i = 0; i < 4; i++)
      issue(1, 64'h7000 + 64'(8*i), 64'h0, 1, 0, 3, 0, 1, 5'(i), 0, {$urandom, $urandom}, 0, sc);
    chk("b2b_cycles", 64'(($time - t0) / 10), 64'd8);

    // Reset while a load is outstanding; its late response must be dropped.
    in_valid = 1; in_aluOut = 64'h4008; in_memRead = 1; in_memWrite = 0; in_memSize = 2'd3;
    bubbleHold = 0;
    b.addr = 64'h4008; b.wr = 0; b.strb = 8'hFF; b.data = '0; b.rdata = 64'h1; b.delay = 4;
    bus_q.push_back(b);
    @(posedge clk); #1;
    @(negedge clk); #2;
    chk("rst_mid_req", 64'(dreq_valid), 64'h1);
    chk("rst_mid_stall", 64'(stall), 64'h1);
    rst = 1'b1; in_valid = 0;
    #1;
    chk("rst_async_req", 64'(dreq_valid), 64'h0);
    chk("rst_async_stall", 64'(stall), 64'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      chk("rst_late_resp", 64'(out_valid), 64'h0);
    end
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      issue($urandom_range(0, 9) != 0, {$urandom, $urandom}, {$urandom, $urandom},
            op >= 4 && op <= 6 || op == 9, op >= 7, $urandom_range(0, 3), 1'($urandom),
            1'($urandom), 5'($urandom), $urandom_range(0, 7) == 0, {$urandom, $urandom},
            $urandom_range(0, 3), sc);
    end

    in_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    chk("sb_drained", 64'(sb_q.size()), 64'h0);
    chk("bus_drained", 64'(bus_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory stage directly downstream of the execute stage.
- Consumes the EX/MEM register fields: ALU result used as the address, rs2 used as store data, writeback control, and instruction tracking.
- Issues load/store transactions on the data bus, aligns and extends load data, and registers the MEM/WB outputs.
- Stalls the pipeline while a bus transaction is outstanding.

Parameters:
- XLEN, 64, datapath and address width.
- REG_ADDR_W, 5, width of the destination register index.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- bubbleHold  in  1  upstream hazard hold; when high, the captured output slot is invalidated
- in_valid  in  1  EX/MEM entry valid
- in_aluOut  in  XLEN  ALU result; effective address for memory operations
- in_rs2  in  XLEN  store data
- in_memRead  in  1  load operation
- in_memWrite  in  1  store operation
- in_memSize  in  2  access size: 0=byte, 1=half, 2=word, 3=double
- in_memUnsigned  in  1  zero-extend the load when high
- in_isWriteBack  in  1  writeback enable
- in_wd  in  REG_ADDR_W  destination register index
- in_instrAddr  in  XLEN  instruction PC
- in_instr  in  32  instruction word
- dreq_valid  out  1  data bus request
- dreq_addr  out  XLEN  request address, aligned down to 8 bytes
- dreq_write  out  1  1=store, 0=load
- dreq_strobe  out  8  byte enables
- dreq_data  out  XLEN  store data, lane-shifted
- dresp_ok  in  1  transaction complete; single-cycle pulse
- dresp_data  in  XLEN  load data, valid with dresp_ok
- stall  out  1  freezes the upstream stages
- out_valid  out  1  MEM/WB entry valid
- out_result  out  XLEN  load value or passed-through ALU result
- out_isWriteBack  out  1  writeback enable
- out_wd  out  REG_ADDR_W  destination register index
- out_instrAddr  out  XLEN  instruction PC
- out_instr  out  32  instruction word
- out_exception  out  1  misaligned-access flag; only present with the optional feature

Behaviour:
- Reset values:
  - FSM state = IDLE.
  - Every output is 0: out_valid, out_exception, dreq_valid, dreq_write, dreq_strobe, stall, and all data outputs.
- FSM states: IDLE, WAIT.
- IDLE, entry with in_valid=1 and no memory operation:
  - Registered to the outputs on the next edge (latency 1).
  - out_result = in_aluOut.
- IDLE, entry with in_valid=1 and memRead or memWrite:
  - Next edge: capture the operation, go to WAIT, drive dreq_valid=1.
  - stall rises combinationally in that same cycle.
  - out_valid=0 on that edge (a bubble moves downstream).
- WAIT:
  - dreq_* are held constant until dresp_ok.
  - stall=1 throughout.
  - Upstream inputs are ignored; upstream is frozen by stall.
- WAIT, cycle with dresp_ok=1:
  - stall=0 combinationally in that cycle.
  - Next edge: dreq_valid=0, out_valid=1, out_result = load value (loads) or in_aluOut (stores); return to IDLE.
  - A new entry can be accepted in the cycle following that edge.
  - dresp_ok is ignored in IDLE.
- Minimum latency of a memory operation: 2 edges, when dresp_ok is seen in the first WAIT cycle.
- Store lanes, with off = addr[2:0]:
  - dreq_data = rs2 << (8*off).
  - dreq_strobe = ((1<<(1<<size))-1) << off, truncated to 8 bits.
- Load alignment:
  - Raw value = dresp_data >> (8*off), masked to the access size.
  - Sign-extended from the size's MSB unless in_memUnsigned=1.
  - Double-size access: the full 64-bit value, no extension.
- bubbleHold:
  - Sampled on the edge that writes the outputs; when high, out_valid = 0 for that edge.
  - An accepted memory operation still completes its bus transaction.
- Entry with both memRead and memWrite: treated as a store.
- Reset mid-transaction: dreq_valid and stall drop immediately (asynchronous), FSM returns to IDLE; a dresp_ok arriving afterwards is discarded.
- in_valid=0: no request, out_valid=0 on the next edge.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A memory access whose address is not size-aligned (addr mod 2^size ≠ 0) issues no bus request and does not enter WAIT.
  - Outputs on the next edge: out_valid=1, out_exception=1, out_isWriteBack=0.
  - out_exception clears on the next output update.
- Not defined:
  - Port out_exception is absent.
  - Misaligned accesses are issued as-is; strobe bits shifted beyond bit 7 are dropped.

Test Plan:
- ALU-only: in_aluOut=0x1234, isWriteBack=1, wd=5 -> next edge out_valid=1, out_result=0x1234, out_wd=5, stall never asserted.
- Signed byte load: addr=0x1003, size=0, dresp_data=0x00000000_80000000 after 3 wait cycles -> stall high for 4 cycles, dreq_addr=0x1000, out_result=0xFFFF_FFFF_FFFF_FF80; unsigned variant -> 0x80.
- Half store: addr=0x2006, rs2=0xABCD, size=1 -> dreq_strobe=0xC0, dreq_data=0xABCD_0000_0000_0000, dreq_write=1; request held stable until dresp_ok.
- Reset asserted in WAIT: dreq_valid and stall fall without a clock edge; a later dresp_ok pulse produces no out_valid.
- bubbleHold=1 during ALU-only entry -> out_valid=0; back-to-back memory ops with immediate dresp_ok -> one result every 2 cycles.
- With MEM_MISALIGN_TRAP_EN: word load at 0x3002 -> dreq_valid stays 0, out_exception=1, out_isWriteBack=0.
